raymarch_frame_scheduler: RTL and testbench

- Sequences one full frame of pixel coordinates into the free-running, non-stallable raymarcher pipeline.
- Tracks in-flight pixels with a valid shift register matched to the pipeline latency.
- Captures returned RGB into a skid FIFO and writes it to the framebuffer over a valid/ready write port.
- Pulses a config-latch strobe so camera registers (look_at, eye) change only between frames.

---
 rtl/raymarch_frame_scheduler.sv | 213 +++++++++++++++++++++
 tb/tb_raymarch_frame_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/raymarch_frame_scheduler.sv
// raymarch_frame_scheduler
//   Walks one frame of pixel coordinates into a fixed-latency, non-stallable
//   raymarcher. It tracks in-flight pixels with a valid shift register,
//   catches returned colours in a skid FIFO and streams them to the
//   framebuffer over a valid/ready write port.
//
//   Issue is credit based. A pixel is issued only while everything that can
//   still land in local storage fits in FIFO_DEPTH entries. That budget
//   covers the pixel on the bus, the pixels in the pipe, the FIFO and the
//   output register. Because it is counted before issue, the FIFO cannot
//   overflow, and a stalled framebuffer simply throttles issue.
//
//   Latency: the output stage is a register in front of the FIFO. With
//   wr_ready=1, if start is accepted in cycle T, pixel (0,0) is on pix_x/pix_y
//   in cycle T+1 and wr_valid first rises in cycle T+1+PIPE_LATENCY+1.
//
// Ports
//   clk, reset_n       clock, asynchronous active-low reset
//   start              frame request, honoured only when idle and not busy
//   busy               registered, high from the cycle after start through frame_done
//   cfg_latch          combinational strobe in the start-accept cycle; camera
//                      shadow registers load on that edge, before the first pixel
//   frame_done         one-cycle pulse, the cycle after the last write is accepted
//   pix_x/pix_y        coordinate to the raymarcher, qualified by pix_valid
//   rgb_in             colour from the raymarcher, PIPE_LATENCY cycles after issue
//   wr_valid/wr_ready  framebuffer write handshake
//   wr_addr/wr_data    linear address y*SCREEN_WIDTH+x and colour
module raymarch_frame_scheduler #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int PIPE_LATENCY  = 96,
  parameter int FIFO_DEPTH    = 16,
  parameter int ADDR_W        = 19
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              cfg_latch,
  output logic              frame_done,
  output logic [9:0]        pix_x,
  output logic [9:0]        pix_y,
  output logic              pix_valid,
  input  logic [23:0]       rgb_in,
  output logic              wr_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [23:0]       wr_data,
  input  logic              wr_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(PIPE_LATENCY + FIFO_DEPTH + 4) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);
  localparam logic [9:0] LAST_X = 10'(SCREEN_WIDTH - 1);
  localparam logic [9:0] LAST_Y = 10'(SCREEN_HEIGHT - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_t;

  state_t                  state_r, state_s;
  logic                    busy_r, frame_done_r, pix_valid_r, last_issued_r;
  logic [9:0]              pix_x_r, pix_y_r, cnt_x_r, cnt_y_r;
  logic [9:0]              cur_x_s, cur_y_s, nxt_x_s, nxt_y_s;
  logic [PIPE_LATENCY-1:0] vsr_r, vsr_s;
  logic [CW-1:0]           inflight_r, fifo_cnt_r, used_s;
  logic [23:0]             mem_r [FIFO_DEPTH];
  logic [PW-1:0]           wptr_r, rptr_r;
  logic                    wr_valid_r;
  logic [ADDR_W-1:0]       wr_addr_r;
  logic [23:0]             wr_data_r;
  logic start_ok_s, issue_s, is_last_s, push_s, pop_out_s, load_out_s;
  logic fifo_rd_s, fifo_wr_s, bypass_s, done_now_s;

  assign busy       = busy_r;
  assign frame_done = frame_done_r;
  assign pix_x      = pix_x_r;
  assign pix_y      = pix_y_r;
  assign pix_valid  = pix_valid_r;
  assign wr_valid   = wr_valid_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  // Gated by reset_n so the strobe is also 0 while reset is held.
  assign cfg_latch  = start_ok_s & reset_n;

  // Issue decision, coordinate stepping and write-port handshake terms.
  always_comb begin
    start_ok_s = (state_r == ST_IDLE) && start && !busy_r;
    // Pixel on the bus is counted as well: it is committed to come back.
    used_s     = CW'(pix_valid_r) + inflight_r + fifo_cnt_r + CW'(wr_valid_r);
    // Start-accept issues (0,0) directly so the first pixel appears at T+1.
    issue_s    = start_ok_s ||
                 ((state_r == ST_RUN) && !last_issued_r && (used_s < CW'(FIFO_DEPTH)));
    cur_x_s    = start_ok_s ? 10'd0 : cnt_x_r;
    cur_y_s    = start_ok_s ? 10'd0 : cnt_y_r;
    is_last_s  = (cur_x_s == LAST_X) && (cur_y_s == LAST_Y);
    if (cur_x_s == LAST_X) begin
      nxt_x_s = 10'd0;
      nxt_y_s = cur_y_s + 10'd1;
    end else begin
      nxt_x_s = cur_x_s + 10'd1;
      nxt_y_s = cur_y_s;
    end
    vsr_s      = vsr_r << 1;
    vsr_s[0]   = pix_valid_r;
    push_s     = vsr_r[PIPE_LATENCY-1];
    pop_out_s  = wr_valid_r && wr_ready;
    load_out_s = !wr_valid_r || pop_out_s;
    fifo_rd_s  = load_out_s && (fifo_cnt_r != '0);
    // An empty FIFO lets a returning colour go straight to the output register.
    bypass_s   = load_out_s && (fifo_cnt_r == '0) && push_s;
    fifo_wr_s  = push_s && !bypass_s;
    done_now_s = (state_r == ST_DRAIN) && pop_out_s && (wr_addr_r == LAST_ADDR);
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (start_ok_s) state_s = ST_RUN; else state_s = ST_IDLE;
      // last_issued_r is high in the cycle the final pixel sits on the bus.
      ST_RUN:   if (last_issued_r) state_s = ST_DRAIN; else state_s = ST_RUN;
      ST_DRAIN: if (done_now_s) state_s = ST_IDLE; else state_s = ST_DRAIN;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State, busy and frame_done registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      // Held through the frame_done cycle, which already sits in IDLE.
      busy_r       <= (state_s != ST_IDLE) || done_now_s;
      frame_done_r <= done_now_s;
    end
  end

  // Pixel issue registers and the next-coordinate counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_valid_r   <= 1'b0;
      pix_x_r       <= 10'd0;
      pix_y_r       <= 10'd0;
      cnt_x_r       <= 10'd0;
      cnt_y_r       <= 10'd0;
      last_issued_r <= 1'b0;
    end else if (issue_s) begin
      pix_valid_r   <= 1'b1;
      pix_x_r       <= cur_x_s;
      pix_y_r       <= cur_y_s;
      cnt_x_r       <= nxt_x_s;
      cnt_y_r       <= nxt_y_s;
      last_issued_r <= is_last_s;
    end else begin
      pix_valid_r   <= 1'b0;
    end
  end

  // In-flight tracking: valid shift register plus an exact popcount counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsr_r      <= '0;
      inflight_r <= '0;
    end else begin
      vsr_r      <= vsr_s;
      inflight_r <= inflight_r + CW'(pix_valid_r) - CW'(push_s);
    end
  end

  // Skid FIFO storage (data only, no reset needed).
  always_ff @(posedge clk) begin
    if (fifo_wr_s) mem_r[wptr_r] <= rgb_in;
  end

  // Skid FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      fifo_cnt_r <= '0;
    end else begin
      if (fifo_wr_s) wptr_r <= wptr_r + PW'(1);
      if (fifo_rd_s) rptr_r <= rptr_r + PW'(1);
      fifo_cnt_r <= fifo_cnt_r + CW'(fifo_wr_s) - CW'(fifo_rd_s);
    end
  end

  // Write-port output register and address counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_valid_r <= 1'b0;
      wr_data_r  <= 24'd0;
      wr_addr_r  <= '0;
    end else begin
      if (load_out_s) begin
        if (fifo_rd_s) begin
          wr_valid_r <= 1'b1;
          wr_data_r  <= mem_r[rptr_r];
        end else if (bypass_s) begin
          wr_valid_r <= 1'b1;
          wr_data_r  <= rgb_in;
        end else begin
          wr_valid_r <= 1'b0;
        end
      end
      if (start_ok_s) wr_addr_r <= '0;
      else if (pop_out_s) wr_addr_r <= (wr_addr_r == LAST_ADDR) ? '0 : wr_addr_r + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_raymarch_frame_scheduler.sv
// Testbench for raymarch_frame_scheduler on a reduced 16x8 frame. A
// behavioural raymarcher returns a colour derived from the coordinate it
// saw PIPE_LATENCY cycles earlier. Every issued pixel is checked against
// the expected raster order, and the expected write (address, colour) is
// pushed to a scoreboard. A monitor pops the scoreboard on each accepted
// write.
module tb_raymarch_frame_scheduler;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int L  = 6;
  localparam int D  = 16;
  localparam int AW = 8;
  localparam int N  = W * H;

  logic clk = 1'b0;
  logic reset_n, start, wr_ready;
  logic busy, cfg_latch, frame_done, pix_valid, wr_valid;
  logic [9:0] pix_x, pix_y;
  logic [23:0] rgb_in, wr_data;
  logic [AW-1:0] wr_addr;

  raymarch_frame_scheduler #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .PIPE_LATENCY(L),
                             .FIFO_DEPTH(D), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy), .cfg_latch(cfg_latch),
    .frame_done(frame_done), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .rgb_in(rgb_in), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk_eq(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] model_rgb(input int x, input int y);
    logic [7:0] xb, yb;
    xb = x[7:0];
    yb = y[7:0];
    return {xb, yb, xb ^ (yb << 3) ^ 8'h5A};
  endfunction

  // Behavioural raymarcher: fixed-latency delay line of coordinates.
  logic [19:0] line_r [L];
  always @(posedge clk) begin
    line_r[0] <= {pix_x, pix_y};
    for (int i = 1; i < L; i++) line_r[i] <= line_r[i-1];
  end
  assign rgb_in = model_rgb(int'(line_r[L-1][19:10]), int'(line_r[L-1][9:0]));

  // wr_ready driver: 0 = always ready, 1 = stalled, 2 = random ~30% duty.
  int rdy_mode = 0;
  initial begin
    wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: wr_ready = 1'b1;
        1: wr_ready = 1'b0;
        default: wr_ready = ($urandom_range(0, 99) < 30);
      endcase
    end
  end

  typedef struct { int addr; logic [23:0] data; } exp_t;
  exp_t q[$];
  int exp_x, exp_y, issued, first_iss, last_iss, first_wr;
  int last_acc_addr = -1, last_acc_cyc = -10;
  int cfg_cnt = 0, done_cnt = 0;
  logic prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [23:0] prev_data;

  // Monitor and scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (pix_valid) begin
        chk_eq("extra_issue", 32'(issued < N), 32'd1);
        chk_eq("pix_order", {12'd0, pix_y, pix_x}, 32'((exp_y << 10) | exp_x));
        e.addr = exp_y * W + exp_x;
        e.data = model_rgb(exp_x, exp_y);
        q.push_back(e);
        issued++;
        if (first_iss < 0) first_iss = cyc;
        last_iss = cyc;
        if (exp_x == W - 1) begin exp_x = 0; exp_y++; end
        else exp_x++;
      end
      chk_eq("credit", 32'(q.size() <= D), 32'd1);
      if (prev_stall) chk_eq("stable", {7'd0, wr_valid, wr_addr, wr_data},
                             {7'd0, 1'b1, prev_addr, prev_data});
      if (wr_valid && first_wr < 0) first_wr = cyc;
      if (wr_valid && wr_ready) begin
        chk_eq("sb_nonempty", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk_eq("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk_eq("wr_data", 32'(wr_data), 32'(e.data));
        end
        last_acc_addr = int'(wr_addr);
        last_acc_cyc  = cyc;
      end
      if (frame_done) begin
        done_cnt++;
        chk_eq("frame_done_timing", {busy, 7'd0, 8'(q.size()), 16'(cyc - last_acc_cyc)},
               {1'b1, 7'd0, 8'd0, 16'd1});
        chk_eq("frame_done_addr", 32'(last_acc_addr), 32'(N - 1));
      end
      if (cfg_latch) cfg_cnt++;
      prev_stall = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  task automatic begin_frame();
    exp_x = 0; exp_y = 0; issued = 0;
    first_iss = -1; last_iss = -1; first_wr = -1;
  endtask

  // Pulse start for one cycle; returns the cycle it was presented in.
  task automatic pulse_start(input logic exp_cfg, input string nm, output int scyc);
    @(posedge clk);
    #1 start = 1'b1;
    scyc = cyc;
    @(negedge clk);
    chk_eq(nm, 32'(cfg_latch), 32'(exp_cfg));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_done(input int limit);
    logic got = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (frame_done) begin got = 1'b1; break; end
    end
    chk_eq("done_timeout", 32'(got), 32'd1);
    @(negedge clk);
    chk_eq("idle_after_done", {30'd0, busy, frame_done}, 32'd0);
    chk_eq("issued_count", 32'(issued), 32'(N));
  endtask

  initial begin
    int s0, sx;
    reset_n = 1'b0;
    start   = 1'b0;
    #22;
    chk_eq("reset_outs", 32'(|{busy, cfg_latch, frame_done, pix_valid, pix_x, pix_y,
                               wr_valid, wr_addr, wr_data}), 32'd0);
    reset_n = 1'b1;
    wait_cycles(3);

    // Frame 1: always ready, latency, continuity, start ignored while busy.
    begin_frame();
    pulse_start(1'b1, "cfg_latch", s0);
    chk_eq("busy_after_start", 32'(busy), 32'd1);
    wait_cycles(40);
    pulse_start(1'b0, "start_while_busy", sx);
    wait_done(2000);
    chk_eq("first_issue_lat", 32'(first_iss - s0), 32'd1);
    chk_eq("first_write_lat", 32'(first_wr - s0), 32'(L + 2));
    chk_eq("issue_continuous", 32'(last_iss - first_iss), 32'(N - 1));
    chk_eq("cfg_pulses_f1", 32'(cfg_cnt), 32'd1);

    // Frame 2: framebuffer stall fills the credit budget, then resumes.
    begin_frame();
    pulse_start(1'b1, "cfg_latch_f2", s0);
    wait_cycles(20);
    rdy_mode = 1;
    wait_cycles(60);
    @(negedge clk);
    chk_eq("bp_fill", 32'(q.size()), 32'(D));
    chk_eq("bp_stall", 32'(pix_valid), 32'd0);
    rdy_mode = 0;
    wait_done(2000);

    // Frame 3: random ready at ~30% duty.
    begin_frame();
    rdy_mode = 2;
    pulse_start(1'b1, "cfg_latch_f3", s0);
    wait_done(6000);
    rdy_mode = 0;

    // Frame 4: asynchronous reset in mid-frame with pixels in flight.
    begin_frame();
    pulse_start(1'b1, "cfg_latch_f4", s0);
    wait_cycles(30);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_eq("async_reset_outs", 32'(|{busy, cfg_latch, frame_done, pix_valid, pix_x, pix_y,
                                     wr_valid, wr_addr, wr_data}), 32'd0);
    q.delete();
    begin_frame();
    wait_cycles(3);
    @(negedge clk);
    #2 reset_n = 1'b1;
    wait_cycles(2);

    // Frame 5: clean frame from address 0 after the reset.
    begin_frame();
    pulse_start(1'b1, "cfg_latch_f5", s0);
    wait_done(2000);
    chk_eq("cfg_pulses_total", 32'(cfg_cnt), 32'd5);
    chk_eq("done_pulses_total", 32'(done_cnt), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
